// File: rtl/ltc2333_acq_scheduler.sv
// Shares one LTC2333 conversion engine between N_REQ requesters: round-robin
// grant, loads the owner's burst config into the engine params, releases reset,
// counts cnv pulses to find the burst end, then acks the owner.
// Ports:
//   clk, aresetn            clock / async active-low reset
//   enable                  allow new grants (a running burst always completes)
//   req[N_REQ]              level requests, held until ack
//   cfg_channels/range/n_reads  per-requester burst config, packed by requester index
//   sample_period           shared delay-state count, captured at grant
//   cnv_mon                 engine cnv output (monitored)
//   grant, ack, err, busy   arbitration status (all registered)
//   w_*                     engine params fields (registered, stable outside IDLE)
module ltc2333_acq_scheduler #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TAIL_CYCLES    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*8-1:0]   cfg_channels,
  input  logic [N_REQ*3-1:0]   cfg_range,
  input  logic [N_REQ*16-1:0]  cfg_n_reads,
  input  logic [31:0]          sample_period,
  input  logic                 cnv_mon,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     ack,
  output logic                 err,
  output logic                 busy,
  output logic                 w_reset,
  output logic                 w_mode,
  output logic [15:0]          w_n_reads,
  output logic [7:0]           w_active_channels,
  output logic [2:0]           w_range,
  output logic [31:0]          w_sample_period
);

  localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned RST_W  = $clog2(RESET_CYCLES + 1);
  localparam int unsigned TAIL_W = $clog2(TAIL_CYCLES + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               w_reset_q, w_reset_d;
  logic [15:0]        w_n_reads_q, w_n_reads_d;
  logic [7:0]         w_ch_q, w_ch_d;
  logic [2:0]         w_range_q, w_range_d;
  logic [31:0]        w_sp_q, w_sp_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [15:0]        cnv_cnt_q, cnv_cnt_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [TAIL_W-1:0]  tail_q, tail_d;
  logic               cnv_prev_q;

  logic               pick_found_c;
  logic [PTR_W-1:0]   pick_idx_c;
  logic [7:0]         pick_ch_c;
  logic [2:0]         pick_range_c;
  logic [15:0]        pick_n_c;
  logic               cnv_rise_c;
  logic [15:0]        cnv_cnt_inc_c;
  logic [PTR_W-1:0]   owner_next_c;

  assign cnv_rise_c    = cnv_mon & ~cnv_prev_q;
  assign cnv_cnt_inc_c = 16'(cnv_cnt_q + 16'd1);
  assign owner_next_c  = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : PTR_W'(owner_q + 1'b1);

  // Round-robin pick: first pending request at or after rr_ptr, wrapping.
  always_comb begin : arb_comb
    int unsigned j;
    j            = 0;
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    pick_ch_c    = '0;
    pick_range_c = '0;
    pick_n_c     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = (32'(rr_ptr_q) + i) % N_REQ;
      if (!pick_found_c && req[j]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = PTR_W'(j);
        pick_ch_c    = cfg_channels[8*j +: 8];
        pick_range_c = cfg_range[3*j +: 3];
        pick_n_c     = cfg_n_reads[16*j +: 16];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ack_d       = '0;
    err_d       = 1'b0;
    w_reset_d   = w_reset_q;
    w_n_reads_d = w_n_reads_q;
    w_ch_d      = w_ch_q;
    w_range_d   = w_range_q;
    w_sp_d      = w_sp_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    rst_cnt_d   = rst_cnt_q;
    cnv_cnt_d   = cnv_cnt_q;
    wdog_d      = wdog_q;
    tail_d      = tail_q;

    unique case (state_q)
      S_IDLE: begin
        w_reset_d = 1'b1;
        if (enable && pick_found_c) begin
          grant_d     = N_REQ'(1) << pick_idx_c;
          owner_d     = pick_idx_c;
          w_n_reads_d = pick_n_c;
          w_ch_d      = pick_ch_c;
          w_range_d   = pick_range_c;
          w_sp_d      = sample_period;
          rst_cnt_d   = '0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
          if (w_n_reads_q == '0) begin
            // Nothing to convert: finish without ever releasing the engine.
            state_d  = S_DONE;
            ack_d    = grant_q;
            grant_d  = '0;
            rr_ptr_d = owner_next_c;
          end else begin
            w_reset_d = 1'b0;
            cnv_cnt_d = '0;
            wdog_d    = '0;
            state_d   = S_RUN;
          end
        end else begin
          rst_cnt_d = RST_W'(rst_cnt_q + 1'b1);
        end
      end
      S_RUN: begin
        if (cnv_rise_c) begin
          cnv_cnt_d = cnv_cnt_inc_c;
          wdog_d    = '0;
          if (cnv_cnt_inc_c == w_n_reads_q) begin
            tail_d  = '0;
            state_d = S_DRAIN;
          end
        end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // Engine stalled: abort the burst and flag it on the ack.
          w_reset_d = 1'b1;
          err_d     = 1'b1;
          ack_d     = grant_q;
          grant_d   = '0;
          rr_ptr_d  = owner_next_c;
          state_d   = S_DONE;
        end else begin
          wdog_d = WD_W'(wdog_q + 1'b1);
        end
      end
      S_DRAIN: begin
        // Wait for the last conversion's cnv to stay low long enough.
        if (cnv_mon) begin
          tail_d = '0;
        end else if (tail_q == TAIL_W'(TAIL_CYCLES - 1)) begin
          w_reset_d = 1'b1;
          ack_d     = grant_q;
          grant_d   = '0;
          rr_ptr_d  = owner_next_c;
          state_d   = S_DONE;
        end else begin
          tail_d = TAIL_W'(tail_q + 1'b1);
        end
      end
      S_DONE: begin
        // One gap cycle so the owner can drop req before re-arbitration.
        w_reset_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        grant_d   = '0;
        w_reset_d = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      w_reset_q   <= 1'b1;
      w_n_reads_q <= '0;
      w_ch_q      <= '0;
      w_range_q   <= '0;
      w_sp_q      <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      rst_cnt_q   <= '0;
      cnv_cnt_q   <= '0;
      wdog_q      <= '0;
      tail_q      <= '0;
      cnv_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      w_reset_q   <= w_reset_d;
      w_n_reads_q <= w_n_reads_d;
      w_ch_q      <= w_ch_d;
      w_range_q   <= w_range_d;
      w_sp_q      <= w_sp_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      rst_cnt_q   <= rst_cnt_d;
      cnv_cnt_q   <= cnv_cnt_d;
      wdog_q      <= wdog_d;
      tail_q      <= tail_d;
      cnv_prev_q  <= cnv_mon;
    end
  end

  assign grant             = grant_q;
  assign ack               = ack_q;
  assign err               = err_q;
  assign busy              = busy_q;
  assign w_reset           = w_reset_q;
  assign w_mode            = 1'b0;
  assign w_n_reads         = w_n_reads_q;
  assign w_active_channels = w_ch_q;
  assign w_range           = w_range_q;
  assign w_sample_period   = w_sp_q;

endmodule

// File: tb/tb_ltc2333_acq_scheduler.sv
// Directed bench for ltc2333_acq_scheduler: reset values, single burst,
// round-robin order, zero-length burst, watchdog abort, enable gating and
// asynchronous reset mid-burst.
module tb_ltc2333_acq_scheduler;

  localparam int unsigned N_REQ = 4;

  logic                clk = 1'b0;
  logic                aresetn;
  logic                enable;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*8-1:0]  cfg_channels;
  logic [N_REQ*3-1:0]  cfg_range;
  logic [N_REQ*16-1:0] cfg_n_reads;
  logic [31:0]         sample_period;
  logic                cnv_mon;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    ack;
  logic                err;
  logic                busy;
  logic                w_reset;
  logic                w_mode;
  logic [15:0]         w_n_reads;
  logic [7:0]          w_active_channels;
  logic [2:0]          w_range;
  logic [31:0]         w_sample_period;

  int n_vec = 0;
  int n_err = 0;

  ltc2333_acq_scheduler #(
    .N_REQ          (N_REQ),
    .RESET_CYCLES   (2),
    .TAIL_CYCLES    (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .enable            (enable),
    .req               (req),
    .cfg_channels      (cfg_channels),
    .cfg_range         (cfg_range),
    .cfg_n_reads       (cfg_n_reads),
    .sample_period     (sample_period),
    .cnv_mon           (cnv_mon),
    .grant             (grant),
    .ack               (ack),
    .err               (err),
    .busy              (busy),
    .w_reset           (w_reset),
    .w_mode            (w_mode),
    .w_n_reads         (w_n_reads),
    .w_active_channels (w_active_channels),
    .w_range           (w_range),
    .w_sample_period   (w_sample_period)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int r, input logic [7:0] ch, input logic [2:0] rng,
                         input logic [15:0] n);
    cfg_channels[8*r +: 8] = ch;
    cfg_range[3*r +: 3]    = rng;
    cfg_n_reads[16*r +: 16] = n;
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) begin
      cnv_mon = 1'b1;
      tick();
      cnv_mon = 1'b0;
      tick();
      tick();
      tick();
    end
  endtask

  task automatic wait_grant();
    for (int c = 0; c < 20 && grant == '0; c++) tick();
  endtask

  task automatic wait_wlow();
    for (int c = 0; c < 20 && w_reset; c++) tick();
  endtask

  task automatic wait_ack(input int limit, output int cyc);
    cyc = 0;
    while (ack == '0 && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  initial begin
    int cyc;
    int exp_idx;
    logic saw_low;

    aresetn       = 1'b0;
    enable        = 1'b1;
    req           = '0;
    cfg_channels  = '0;
    cfg_range     = '0;
    cfg_n_reads   = '0;
    sample_period = 32'h0;
    cnv_mon       = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_w_reset", 64'(w_reset), 64'h1);
    chk("rst_w_mode", 64'(w_mode), 64'h0);
    chk("rst_w_n_reads", 64'(w_n_reads), 64'h0);
    chk("rst_w_ch", 64'(w_active_channels), 64'h0);
    chk("rst_w_range", 64'(w_range), 64'h0);
    chk("rst_w_sp", 64'(w_sample_period), 64'h0);
    aresetn = 1'b1;
    tick();

    // Single burst on requester 0
    set_cfg(0, 8'h05, 3'd5, 16'd3);
    sample_period = 32'h0000_1234;
    req = 4'b0001;
    tick();
    chk("t1_grant", 64'(grant), 64'h1);
    chk("t1_busy", 64'(busy), 64'h1);
    chk("t1_n_reads", 64'(w_n_reads), 64'd3);
    chk("t1_ch", 64'(w_active_channels), 64'h05);
    chk("t1_range", 64'(w_range), 64'd5);
    chk("t1_sp", 64'(w_sample_period), 64'h1234);
    sample_period = 32'hdead_beef;
    tick();
    chk("t1_wreset_hold", 64'(w_reset), 64'h1);
    tick();
    chk("t1_wreset_rel", 64'(w_reset), 64'h0);
    pulses(2);
    chk("t1_no_early_ack", 64'(ack), 64'h0);
    chk("t1_sp_stable", 64'(w_sample_period), 64'h1234);
    pulses(1);
    wait_ack(40, cyc);
    chk("t1_ack", 64'(ack), 64'h1);
    chk("t1_err", 64'(err), 64'h0);
    chk("t1_grant_clr", 64'(grant), 64'h0);
    chk("t1_wreset_done", 64'(w_reset), 64'h1);
    req = '0;
    tick();
    chk("t1_ack_pulse", 64'(ack), 64'h0);
    tick();
    chk("t1_busy_idle", 64'(busy), 64'h0);

    // Round robin with all requests held
    do_reset();
    for (int r = 0; r < 4; r++) set_cfg(r, 8'(8'h10 + r), 3'(r), 16'd2);
    req = 4'b1111;
    wait_grant();
    exp_idx = 0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), 64'(grant), 64'(4'b0001 << exp_idx));
      chk($sformatf("rr_ch%0d", k), 64'(w_active_channels), 64'(8'h10 + exp_idx));
      wait_wlow();
      pulses(2);
      wait_ack(40, cyc);
      chk($sformatf("rr_ack%0d", k), 64'(ack), 64'(4'b0001 << exp_idx));
      chk($sformatf("rr_err%0d", k), 64'(err), 64'h0);
      tick();
      chk($sformatf("rr_gap%0d", k), 64'(grant), 64'h0);
      tick();
      exp_idx = (exp_idx + 1) % 4;
    end
    req = '0;

    // Zero-length burst on requester 2
    do_reset();
    set_cfg(2, 8'hff, 3'd7, 16'd0);
    req = 4'b0100;
    wait_grant();
    chk("z_grant", 64'(grant), 64'h4);
    saw_low = 1'b0;
    cyc = 0;
    while (ack == '0 && cyc < 10) begin
      tick();
      cyc++;
      if (!w_reset) saw_low = 1'b1;
    end
    chk("z_ack", 64'(ack), 64'h4);
    chk("z_latency", 64'(cyc), 64'd2);
    chk("z_never_released", 64'(saw_low), 64'h0);
    req = '0;
    tick();

    // Watchdog abort on requester 1 (rr_ptr is 3, so this also wraps)
    set_cfg(1, 8'h3c, 3'd2, 16'd5);
    req = 4'b0010;
    wait_grant();
    chk("to_grant", 64'(grant), 64'h2);
    wait_wlow();
    wait_ack(200, cyc);
    chk("to_cycles", 64'(cyc), 64'd100);
    chk("to_ack", 64'(ack), 64'h2);
    chk("to_err", 64'(err), 64'h1);
    chk("to_wreset", 64'(w_reset), 64'h1);
    req = '0;
    tick();
    chk("to_err_pulse", 64'(err), 64'h0);
    tick();

    // Enable gating on requester 3
    set_cfg(3, 8'h81, 3'd3, 16'd2);
    enable = 1'b0;
    req = 4'b1000;
    for (int c = 0; c < 5; c++) tick();
    chk("en_no_grant", 64'(grant), 64'h0);
    chk("en_no_busy", 64'(busy), 64'h0);
    enable = 1'b1;
    tick();
    chk("en_grant", 64'(grant), 64'h8);
    wait_wlow();
    enable = 1'b0;
    pulses(2);
    wait_ack(40, cyc);
    chk("en_ack", 64'(ack), 64'h8);
    req = '0;
    enable = 1'b1;
    tick();
    tick();

    // Move rr_ptr to 2, then reset in the middle of a burst on requester 2
    set_cfg(1, 8'h3c, 3'd2, 16'd0);
    req = 4'b0010;
    wait_grant();
    wait_ack(10, cyc);
    chk("pre_ack", 64'(ack), 64'h2);
    req = '0;
    tick();
    tick();
    set_cfg(2, 8'h42, 3'd1, 16'd4);
    req = 4'b0100;
    wait_grant();
    chk("ar_grant", 64'(grant), 64'h4);
    wait_wlow();
    pulses(1);
    aresetn = 1'b0;
    #1;
    chk("ar_grant_clr", 64'(grant), 64'h0);
    chk("ar_busy_clr", 64'(busy), 64'h0);
    chk("ar_wreset", 64'(w_reset), 64'h1);
    req = '0;
    tick();
    tick();
    chk("ar_no_ack", 64'(ack), 64'h0);
    aresetn = 1'b1;
    tick();
    chk("ar_no_ack_after", 64'(ack), 64'h0);
    set_cfg(0, 8'h11, 3'd4, 16'd1);
    req = 4'b0101;
    wait_grant();
    chk("ar_rr_restart", 64'(grant), 64'h1);
    chk("ar_n_reads", 64'(w_n_reads), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
